mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_pkg.sv | 36 +++
 rtl/load_align.sv | 41 ++++
 rtl/mem_access.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the MEM-stage data-cache access block.
//   - Access width encodings (MEM_BYTE / MEM_HALF / MEM_WORD; 2'b11 acts as word)
//   - FSM state encoding used by mem_access (IDLE / BUSY / DONE)
//   - Byte-enable lane constants used to build store/load lane masks
//   - is_aligned(): natural-alignment test for a width/offset pair
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Lane masks before shifting by the byte offset.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Bytes are always aligned; halves need offset[0]=0; words (and the
    // reserved 2'b11 encoding) need offset=0.
    function automatic logic is_aligned(input logic [1:0] width,
                                        input logic [1:0] offset);
        logic ok;
        case (width)
            MEM_BYTE: ok = 1'b1;
            MEM_HALF: ok = ~offset[0];
            default:  ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data formatter.
//   Picks the byte or half-word addressed by offset out of the captured
//   little-endian data word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_word [31:0]  captured data-cache word
//   offset     [1:0]   byte offset of the access (address bits [1:0])
//   width      [1:0]   access width (MEM_BYTE / MEM_HALF / word)
//   rdtype             1 = zero-extend, 0 = sign-extend
//   result     [31:0]  extended load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        rdtype,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata_word[7:0];
            2'd1:    byte_sel = rdata_word[15:8];
            2'd2:    byte_sel = rdata_word[23:16];
            default: byte_sel = rdata_word[31:24];
        endcase

        // Halves are only ever issued aligned, so offset[1] picks the half.
        half_sel = offset[1] ? rdata_word[31:16] : rdata_word[15:0];

        case (width)
            MEM_BYTE: result = {{24{~rdtype & byte_sel[7]}}, byte_sel};
            MEM_HALF: result = {{16{~rdtype & half_sel[15]}}, half_sel};
            default:  result = rdata_word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage data-cache access controller.
//   Turns the memory-op fields of the EX/MEM register into a single
//   data-cache request, stalls the pipeline until the access completes,
//   formats load data and drives the MEM/WB write-back fields.
//
// Cache handshake: mem_Dcache_req_o is a registered request that, once
//   raised, holds together with we/addr/wdata/be unchanged until the cycle
//   in which Dcache_ack_i=1; the transfer completes in that cycle (rdata is
//   valid only then) and req drops on the following edge. An ack seen while
//   no request is outstanding is ignored.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ex_mem_reg_*_i                   EX/MEM register contents (ALU result,
//                                    destination, memory-op descriptor)
//   mem_Dcache_req/we/addr/wdata/be  request to the data cache
//   Dcache_ack_i, Dcache_rdata_i     completion and load data from the cache
//   mem_reg_wdata/waddr/we_o         write-back fields to MEM/WB
//   mem_Dcache_stall_req_o           pipeline stall request to flow control
//   mem_misalign_o                   misaligned-access indication
//   dbg_state                        current FSM state (mem_state_e encoding)
module mem_access
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ex_mem_reg_op_c_i,
    input  logic [4:0]  ex_mem_reg_reg_waddr_i,
    input  logic        ex_mem_reg_reg_we_i,
    input  logic        ex_mem_reg_mtype_i,
    input  logic        ex_mem_reg_mem_rw_i,
    input  logic [1:0]  ex_mem_reg_mem_width_i,
    input  logic [31:0] ex_mem_reg_mem_wr_data_i,
    input  logic        ex_mem_reg_mem_rdtype_i,
    input  logic [31:0] ex_mem_reg_mem_addr_i,

    output logic        mem_Dcache_req_o,
    output logic        mem_Dcache_we_o,
    output logic [31:0] mem_Dcache_addr_o,
    output logic [31:0] mem_Dcache_wdata_o,
    output logic [3:0]  mem_Dcache_be_o,

    input  logic        Dcache_ack_i,
    input  logic [31:0] Dcache_rdata_i,

    output logic [31:0] mem_reg_wdata_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic        mem_reg_we_o,
    output logic        mem_Dcache_stall_req_o,
    output logic        mem_misalign_o,

    output logic [1:0]  dbg_state
);

    mem_state_e  state_q, state_d;
    logic        req_q,   req_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] rdata_q, rdata_d;

    logic        aligned;
    logic        access_ok;
    logic        misalign_raw;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] load_result;

    assign aligned      = is_aligned(ex_mem_reg_mem_width_i, ex_mem_reg_mem_addr_i[1:0]);
    assign access_ok    = ex_mem_reg_mtype_i & aligned;
    assign misalign_raw = ex_mem_reg_mtype_i & ~aligned;

    // Store lane replication and byte enables.
    always_comb begin
        case (ex_mem_reg_mem_width_i)
            MEM_BYTE: begin
                st_wdata = {4{ex_mem_reg_mem_wr_data_i[7:0]}};
                st_be    = BE_BYTE << ex_mem_reg_mem_addr_i[1:0];
            end
            MEM_HALF: begin
                st_wdata = {2{ex_mem_reg_mem_wr_data_i[15:0]}};
                st_be    = BE_HALF << ex_mem_reg_mem_addr_i[1:0];
            end
            default: begin
                st_wdata = ex_mem_reg_mem_wr_data_i;
                st_be    = BE_WORD;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (access_ok) begin
                    req_d   = 1'b1;
                    we_d    = ex_mem_reg_mem_rw_i;
                    addr_d  = {ex_mem_reg_mem_addr_i[31:2], 2'b00};
                    wdata_d = ex_mem_reg_mem_rw_i ? st_wdata : 32'd0;
                    be_d    = ex_mem_reg_mem_rw_i ? st_be : BE_WORD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (Dcache_ack_i) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = Dcache_rdata_i;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_word (rdata_q),
        .offset     (ex_mem_reg_mem_addr_i[1:0]),
        .width      (ex_mem_reg_mem_width_i),
        .rdtype     (ex_mem_reg_mem_rdtype_i),
        .result     (load_result)
    );

    assign mem_Dcache_req_o   = req_q;
    assign mem_Dcache_we_o    = we_q;
    assign mem_Dcache_addr_o  = addr_q;
    assign mem_Dcache_wdata_o = wdata_q;
    assign mem_Dcache_be_o    = be_q;

    // The EX/MEM register is frozen while stall is high, so the op stays on
    // the inputs through DONE; DONE drops the stall to let it retire.
    // rst gates both flags because the inputs may carry a live op in reset.
    assign mem_Dcache_stall_req_o = ~rst & access_ok & (state_q != DONE);
    assign mem_misalign_o         = ~rst & misalign_raw & (state_q == IDLE);

    assign mem_reg_waddr_o = ex_mem_reg_reg_waddr_i;
    assign mem_reg_we_o    = ex_mem_reg_reg_we_i & ~mem_Dcache_stall_req_o & ~misalign_raw;
    assign mem_reg_wdata_o = (state_q == DONE && ex_mem_reg_mtype_i && !ex_mem_reg_mem_rw_i)
                             ? load_result : ex_mem_reg_op_c_i;

    assign dbg_state = state_q;

endmodule
